pwm_peripheral: RTL
===================

// Module: pwm_peripheral
// PURPOSE
//  - Consumes the five configuration bytes written over SPI (output enables, PWM enables, duty cycle).
//  - Drives the 16 user outputs: each is forced low, held high, or driven by a shared 8-bit PWM waveform.
//  - Sits directly downstream of the SPI register block, in the same clk domain; no CDC inside this block.
// PARAMETERS
//  - PRESCALE  default 13  clk cycles per PWM counter tick (>=1); 10 MHz / (13*256) = ~3.0 kHz PWM period
//  - CNT_W     default 8   PWM counter / duty width; period = 2**CNT_W ticks
// PORTS
//  - clk              in   1      system clock; all logic on its rising edge
//  - rst_n            in   1      reset; asynchronous assert, active-low
//  - en_reg_out_7_0   in   8      per-bit output enable, outputs 7..0
//  - en_reg_out_15_8  in   8      per-bit output enable, outputs 15..8
//  - en_reg_pwm_7_0   in   8      per-bit PWM select, outputs 7..0
//  - en_reg_pwm_15_8  in   8      per-bit PWM select, outputs 15..8
//  - pwm_duty_cycle   in   CNT_W  requested duty; 0x00 = 0 %, 0xFF = 100 %
//  - out              out  16     registered user outputs, out[15:8] -> uio_out, out[7:0] -> uo_out
//  - period_start     out  1      one-clk pulse when the counter wraps to 0 (new period begins)
// BEHAVIOUR
//  - Reset (async, rst_n=0): presc_cnt=0, pwm_cnt=0, duty_sh=0, out=16'h0000, period_start=0.
//    Deassertion needs no synchroniser; first tick occurs PRESCALE clks after release.
//  - Prescaler: presc_cnt counts 0..PRESCALE-1 then wraps.
//    tick=1 for exactly one clk when presc_cnt==PRESCALE-1; PRESCALE=1 gives tick every clk.
//  - Counter: pwm_cnt increments on tick, wraps 2**CNT_W-1 -> 0. Holds value between ticks.
//  - Shadow duty: duty_sh <= pwm_duty_cycle only on the tick where pwm_cnt wraps to 0.
//    Same clk, period_start=1. A duty write mid-period never glitches the current period.
//  - pwm_raw = (duty_sh == all-ones) ? 1 : (pwm_cnt < duty_sh), combinational, unsigned compare.
//    Gives high time duty_sh ticks per 256-tick period; 0xFF is forced to a true 100 %.
//  - Per bit i (en_out = {15_8,7_0}, en_pwm likewise):
//      en_out[i]=0 -> out[i]=0 (en_pwm[i] ignored);
//      en_out[i]=1 & en_pwm[i]=0 -> out[i]=1;
//      en_out[i]=1 & en_pwm[i]=1 -> out[i]=pwm_raw.
//  - Latency: out registered; an enable change appears on out exactly 1 clk later.
//    A duty change appears at the next period boundary + 1 clk.
//  - All PWM-selected bits share one waveform; they are phase-aligned and change on the same clk edge.
//  - Simultaneous events: a duty write on the wrap tick is captured in that same tick (new value used at once).
//    An enable change on a wrap tick takes effect with that tick's pwm_raw.
//  - Reset mid-period: outputs go to 0 immediately (async). Counter restarts at 0 and duty_sh=0, so
//    PWM bits stay low for the whole first period until the first wrap loads the live duty.
//  - Inputs are not held by this block; they are sampled every clk.
// STRUCTURE
//  - pwm_pkg: CNT_W default, DUTY_FULL (all-ones), NUM_OUT=16, PRESCALE default.
//  - Sub-module pwm_prescaler (clk, rst_n -> tick), parameterised by PRESCALE.
//  - Counter, shadow register, comparator and output mux stay in the top module.
// TESTING
//  - Reset: hold rst_n=0 with all enables 0xFF and duty 0x80 -> out==0, period_start==0; release ->
//    first period_start at (PRESCALE*256) clks.
//  - Static: en_out=16'hFFFF, en_pwm=0 -> out==16'hFFFF after 1 clk.
//    en_out=16'h00F0 -> out==16'h00F0 exactly 1 clk later.
//  - Duty 0x80, en_out=en_pwm=16'h0001 -> out[0] high for 128 ticks of every 256
//    (1664 of 3328 clks at PRESCALE=13); out[15:1]=0.
//  - Extremes: duty 0x00 -> out[0] never high over 3 periods; duty 0xFF -> out[0] never low over 3 periods.
//  - Mid-period write: duty 0x40 -> 0xC0 at pwm_cnt=0x20 -> current period high 64 ticks, next period high 192.
//    No glitch at the write instant.
//  - Async reset mid-period (pwm_cnt=0x10, out[0]=1): out->0 without a clk edge.
//    After release, the first full period is all-low, the second follows the duty.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and the per-output mode decode used by the PWM output block.
package pwm_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int PRESCALE_DEF = 13;
    localparam int NUM_OUT      = 16;
    localparam logic [CNT_W_DEF-1:0] DUTY_FULL = 8'hFF;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_HIGH = 2'd1,
        MODE_PWM  = 2'd2
    } out_mode_e;

    // Output-enable dominates: a disabled output ignores its PWM select.
    function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
        out_mode_e mode;
        if (!en_out) begin
            mode = MODE_OFF;
        end else if (!en_pwm) begin
            mode = MODE_HIGH;
        end else begin
            mode = MODE_PWM;
        end
        return mode;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Configuration bytes from the SPI register block and the resulting user outputs.
interface pwm_if #(
    parameter int CNT_W = pwm_pkg::CNT_W_DEF
);
    logic [7:0]                   en_reg_out_7_0;
    logic [7:0]                   en_reg_out_15_8;
    logic [7:0]                   en_reg_pwm_7_0;
    logic [7:0]                   en_reg_pwm_15_8;
    logic [CNT_W-1:0]             pwm_duty_cycle;
    logic [pwm_pkg::NUM_OUT-1:0]  out;
    logic                         period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out, period_start
    );
endinterface

// File: rtl/pwm_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE clocks; PRESCALE=1 ticks every clock.
module pwm_prescaler #(
    parameter int PRESCALE = pwm_pkg::PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] presc_cnt_r;

    // Free-running modulo-PRESCALE counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= {W{1'b0}};
        end else if (presc_cnt_r == LAST) begin
            presc_cnt_r <= {W{1'b0}};
        end else begin
            presc_cnt_r <= presc_cnt_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (presc_cnt_r == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator driving 16 user outputs that are each off, held high, or PWM.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    pwm_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               tick_s;
    logic               wrap_s;
    logic               pwm_raw_s;
    logic [CNT_W-1:0]   pwm_cnt_r;
    logic [CNT_W-1:0]   duty_sh_r;
    logic               period_start_r;
    logic [NUM_OUT-1:0] en_out_s;
    logic [NUM_OUT-1:0] en_pwm_s;
    logic [NUM_OUT-1:0] out_next_s;
    logic [NUM_OUT-1:0] out_r;

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    assign en_out_s = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm_s = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign wrap_s   = tick_s && (pwm_cnt_r == CNT_MAX);

    // Period counter advances once per prescaler tick and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Duty is shadowed only at the period boundary so a mid-period write never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_r      <= {CNT_W{1'b0}};
            period_start_r <= 1'b0;
        end else if (wrap_s) begin
            duty_sh_r      <= bus.pwm_duty_cycle;
            period_start_r <= 1'b1;
        end else begin
            duty_sh_r      <= duty_sh_r;
            period_start_r <= 1'b0;
        end
    end

    // All-ones duty is forced to a true 100 % instead of 255/256.
    always_comb begin
        pwm_raw_s = 1'b0;
        if (duty_sh_r == CNT_MAX) begin
            pwm_raw_s = 1'b1;
        end else begin
            pwm_raw_s = (pwm_cnt_r < duty_sh_r);
        end
    end

    // Per-output mux between off, static high and the shared waveform.
    always_comb begin
        out_next_s = {NUM_OUT{1'b0}};
        for (int i = 0; i < NUM_OUT; i++) begin
            case (out_mode(en_out_s[i], en_pwm_s[i]))
                MODE_OFF:  out_next_s[i] = 1'b0;
                MODE_HIGH: out_next_s[i] = 1'b1;
                MODE_PWM:  out_next_s[i] = pwm_raw_s;
                default:   out_next_s[i] = 1'b0;
            endcase
        end
    end

    // Registered user outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= {NUM_OUT{1'b0}};
        end else begin
            out_r <= out_next_s;
        end
    end

    assign bus.out          = out_r;
    assign bus.period_start = period_start_r;

endmodule
